// File: rtl/obstacle_scheduler_if.sv
// Spawn handshake between the obstacle scheduler and the obstacle renderer/mover.
// The scheduler drives the offered obstacle; the renderer answers with ready.
interface obstacle_scheduler_if;
    logic       spawn_valid;
    logic       spawn_ready;
    logic [1:0] obs_type;
    logic       obs_height;

    modport master (output spawn_valid, output obs_type, output obs_height, input spawn_ready);
    modport slave  (input spawn_valid, input obs_type, input obs_height, output spawn_ready);
endinterface

// File: rtl/obstacle_scheduler.sv
// Turns LFSR samples into obstacle spawns: type, bird height and a frame-tick gap,
// offered over a valid/ready handshake and frozen after a collision.
module obstacle_scheduler #(
    parameter int MIN_GAP = 8,
    parameter int GAP_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 game_active,
    input  logic                 collision,
    input  logic [1:0]           speed_level,
    input  logic [4:0]           random_in,
    obstacle_scheduler_if.master spawn,
    output logic [GAP_W-1:0]     gap_count,
    output logic [7:0]           obs_count,
    output logic                 halted
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WAIT  = 3'd2,
        SPAWN = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic             spawn_valid_reg, spawn_valid_next;
    logic [1:0]       obs_type_reg, obs_type_next;
    logic             obs_height_reg, obs_height_next;
    logic [GAP_W-1:0] gap_count_reg, gap_count_next;
    logic [7:0]       obs_count_reg, obs_count_next;
    logic             halted_reg, halted_next;

    logic [3:0]       gap_extra;
    logic [1:0]       sampled_type;

    // Faster levels shrink the random part of the gap, never the minimum.
    assign gap_extra    = random_in[3:0] >> speed_level;
    assign sampled_type = (random_in[1:0] == 2'b11) ? 2'd2 :
                          (random_in[1:0] == 2'b10) ? 2'd1 : 2'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            spawn_valid_reg <= 1'b0;
            obs_type_reg    <= 2'd0;
            obs_height_reg  <= 1'b0;
            gap_count_reg   <= '0;
            obs_count_reg   <= 8'd0;
            halted_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            spawn_valid_reg <= spawn_valid_next;
            obs_type_reg    <= obs_type_next;
            obs_height_reg  <= obs_height_next;
            gap_count_reg   <= gap_count_next;
            obs_count_reg   <= obs_count_next;
            halted_reg      <= halted_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        spawn_valid_next = spawn_valid_reg;
        obs_type_next    = obs_type_reg;
        obs_height_next  = obs_height_reg;
        gap_count_next   = gap_count_reg;
        obs_count_next   = obs_count_reg;
        halted_next      = halted_reg;

        case (state_reg)
            IDLE: begin
                if (game_active) begin
                    state_next     = LOAD;
                    obs_count_next = 8'd0;
                end
            end
            LOAD, WAIT, SPAWN: begin
                // Collision wins over game end, handshake and tick alike.
                if (collision) begin
                    state_next       = HALT;
                    spawn_valid_next = 1'b0;
                    halted_next      = 1'b1;
                end else if (!game_active) begin
                    state_next       = IDLE;
                    spawn_valid_next = 1'b0;
                    gap_count_next   = '0;
                end else if (state_reg == LOAD) begin
                    gap_count_next  = GAP_W'(MIN_GAP) + GAP_W'(gap_extra);
                    obs_type_next   = sampled_type;
                    obs_height_next = (sampled_type == 2'd2) ? random_in[4] : 1'b0;
                    state_next      = WAIT;
                end else if (state_reg == WAIT) begin
                    if (tick) begin
                        if (gap_count_reg <= GAP_W'(1)) begin
                            gap_count_next   = '0;
                            spawn_valid_next = 1'b1;
                            state_next       = SPAWN;
                        end else begin
                            gap_count_next = gap_count_reg - GAP_W'(1);
                        end
                    end
                end else if (spawn_valid_reg && spawn.spawn_ready) begin
                    spawn_valid_next = 1'b0;
                    state_next       = LOAD;
                    if (obs_count_reg != 8'hFF)
                        obs_count_next = obs_count_reg + 8'd1;
                end
            end
            HALT: begin
                if (!game_active) begin
                    state_next     = IDLE;
                    halted_next    = 1'b0;
                    gap_count_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign spawn.spawn_valid = spawn_valid_reg;
    assign spawn.obs_type    = obs_type_reg;
    assign spawn.obs_height  = obs_height_reg;
    assign gap_count         = gap_count_reg;
    assign obs_count         = obs_count_reg;
    assign halted            = halted_reg;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: unit A uses MIN_GAP=8, unit B uses MIN_GAP=1
// for the obs_count saturation run.
module tb_obstacle_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, game_active = 1'b0, collision = 1'b0;
    logic [1:0] speed_level = 2'd0;
    logic [4:0] random_in = 5'd0;
    logic [7:0] gap_count, obs_count;
    logic       halted;

    logic       tick_b = 1'b0, game_b = 1'b0;
    logic [4:0] random_b = 5'd0;
    logic [7:0] gap_count_b, obs_count_b;
    logic       halted_b;

    int n_pass = 0;
    int n_total = 0;
    int accepts;
    int budget;

    obstacle_scheduler_if sif_a ();
    obstacle_scheduler_if sif_b ();

    obstacle_scheduler #(.MIN_GAP(8), .GAP_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick), .game_active(game_active),
        .collision(collision), .speed_level(speed_level), .random_in(random_in),
        .spawn(sif_a), .gap_count(gap_count), .obs_count(obs_count), .halted(halted)
    );

    obstacle_scheduler #(.MIN_GAP(1), .GAP_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick_b), .game_active(game_b),
        .collision(1'b0), .speed_level(2'd0), .random_in(random_b),
        .spawn(sif_b), .gap_count(gap_count_b), .obs_count(obs_count_b), .halted(halted_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        sif_a.spawn_ready = 1'b0;
        sif_b.spawn_ready = 1'b0;
        #12;
        check("rst_valid", sif_a.spawn_valid, 0);
        check("rst_type", sif_a.obs_type, 0);
        check("rst_height", sif_a.obs_height, 0);
        check("rst_gap", gap_count, 0);
        check("rst_count", obs_count, 0);
        check("rst_halted", halted, 0);
        step();
        rst_n = 1'b1;

        // Game start, first obstacle from 5'b10110 at speed 0
        random_in = 5'b10110; speed_level = 2'd0; game_active = 1'b1;
        step();
        check("start_count", obs_count, 0);
        step();
        check("load1_gap", gap_count, 14);
        check("load1_type", sif_a.obs_type, 1);
        check("load1_height", sif_a.obs_height, 0);
        random_in = 5'b00011;
        tick = 1'b1;
        for (int i = 0; i < 13; i++) step();
        check("t13_gap", gap_count, 1);
        check("t13_valid", sif_a.spawn_valid, 0);
        step();
        check("t14_gap", gap_count, 0);
        check("t14_valid", sif_a.spawn_valid, 1);

        // Stall: ready low for 20 cycles with 5 ticks
        for (int i = 0; i < 20; i++) begin
            tick = (i % 4 == 0);
            step();
            check("stall_valid", sif_a.spawn_valid, 1);
            check("stall_type", sif_a.obs_type, 1);
            check("stall_gap", gap_count, 0);
        end
        tick = 1'b0;

        random_in = 5'b11111; speed_level = 2'd2; sif_a.spawn_ready = 1'b1;
        step();
        check("acc1_valid", sif_a.spawn_valid, 0);
        check("acc1_count", obs_count, 1);
        step();
        check("load2_gap", gap_count, 11);
        check("load2_type", sif_a.obs_type, 2);
        check("load2_height", sif_a.obs_height, 1);
        tick = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("t10_valid", sif_a.spawn_valid, 0);
        step();
        check("t11_valid", sif_a.spawn_valid, 1);
        tick = 1'b0; random_in = 5'b00000; speed_level = 2'd0;
        step();
        check("one_cycle_valid", sif_a.spawn_valid, 0);
        check("acc2_count", obs_count, 2);
        sif_a.spawn_ready = 1'b0;
        step();
        check("load3_gap", gap_count, 8);
        check("load3_type", sif_a.obs_type, 0);

        // Collision in WAIT at gap 5
        tick = 1'b1;
        for (int i = 0; i < 3; i++) step();
        tick = 1'b0;
        check("pre_coll_gap", gap_count, 5);
        collision = 1'b1;
        step();
        collision = 1'b0;
        check("coll_halted", halted, 1);
        tick = 1'b1;
        for (int i = 0; i < 10; i++) step();
        tick = 1'b0;
        check("halt_gap", gap_count, 5);
        check("halt_valid", sif_a.spawn_valid, 0);
        check("halt_count", obs_count, 2);
        game_active = 1'b0;
        step();
        check("exit_halted", halted, 0);
        check("exit_gap", gap_count, 0);
        check("exit_count", obs_count, 2);

        // Collision and ready in the same SPAWN cycle
        random_in = 5'b00001; game_active = 1'b1;
        step();
        check("restart_count", obs_count, 0);
        step();
        check("load4_gap", gap_count, 9);
        tick = 1'b1;
        for (int i = 0; i < 9; i++) step();
        tick = 1'b0;
        check("spawn4_valid", sif_a.spawn_valid, 1);
        sif_a.spawn_ready = 1'b1; collision = 1'b1;
        step();
        sif_a.spawn_ready = 1'b0; collision = 1'b0;
        check("cr_valid", sif_a.spawn_valid, 0);
        check("cr_count", obs_count, 0);
        check("cr_halted", halted, 1);
        game_active = 1'b0;
        step();
        check("cr_exit", halted, 0);

        // Saturation on unit B: 260 accepts, 3 cycles each
        random_b = 5'b00000; game_b = 1'b1; tick_b = 1'b1; sif_b.spawn_ready = 1'b1;
        accepts = 0;
        budget = 0;
        while (accepts < 260 && budget < 2000) begin
            step();
            if (sif_b.spawn_valid) accepts++;
            budget++;
        end
        check("sat_budget", int'(budget < 2000), 1);
        step();
        check("sat_count", obs_count_b, 255);
        game_b = 1'b0; tick_b = 1'b0; sif_b.spawn_ready = 1'b0;
        step();
        check("idle_keep_count", obs_count_b, 255);
        random_b = 5'b01111; game_b = 1'b1;
        step();
        check("restart_clear", obs_count_b, 0);
        step();
        check("b_load_gap", gap_count_b, 16);

        // Asynchronous reset mid-WAIT
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_gap", gap_count_b, 0);
        check("arst_count", obs_count_b, 0);
        check("arst_halted", halted_b, 0);
        check("arst_valid", sif_b.spawn_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
- Consumer of the 5-bit pseudo-random value from the jump-driven LFSR.
- Turns each sampled value into an obstacle type, a bird height and a frame-tick gap until the next spawn.
- Presents each obstacle to the obstacle renderer/mover over a valid/ready handshake.
- Sits between the RNG and the obstacle sprite logic; paced by the game frame tick.

Parameters:
- MIN_GAP, 8: minimum frame ticks between spawns; must be ≥1.
- GAP_W, 8: width of the gap counter; must satisfy MIN_GAP+15 < 2^GAP_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tick  in  1  one-cycle frame tick pulse.
- game_active  in  1  level: game running.
- collision  in  1  level/pulse: dino hit an obstacle.
- speed_level  in  2  difficulty, 0..3.
- random_in  in  5  current LFSR value.
- spawn_ready  in  1  obstacle logic accepts a spawn.
- spawn_valid  out  1  obstacle offered.
- obs_type  out  2  0 = small cactus, 1 = large cactus, 2 = bird, 3 unused.
- obs_height  out  1  bird altitude: 0 = low, 1 = high; 0 for cacti.
- gap_count  out  GAP_W  ticks remaining before spawn.
- obs_count  out  8  obstacles accepted this game, saturating.
- halted  out  1  scheduler frozen after collision.

Behaviour:
- Async reset, all outputs 0, state IDLE:
  - spawn_valid=0, obs_type=0, obs_height=0, gap_count=0, obs_count=0, halted=0.
- States: IDLE, LOAD, WAIT, SPAWN, HALT.
- All outputs are registered.
- IDLE:
  - game_active=1 → LOAD.
  - obs_count clears to 0 on this transition.
- LOAD (exactly 1 cycle), samples random_in:
  - gap_count ← MIN_GAP + (random_in[3:0] >> speed_level), zero-extended to GAP_W.
  - random_in[1:0]: 00/01 → type 0, 10 → type 1, 11 → type 2.
  - obs_height ← random_in[4] if type 2, else 0.
  - Next state WAIT.
  - A tick during LOAD is ignored.
- WAIT:
  - Each tick decrements gap_count.
  - Tick with gap_count==1: gap_count ← 0, next state SPAWN.
  - spawn_valid=1 is registered on that same edge, so it is high in the first SPAWN cycle.
  - With no tick, gap_count holds.
- SPAWN:
  - spawn_valid, obs_type and obs_height are held stable until spawn_ready=1 is sampled with spawn_valid=1.
  - On acceptance: spawn_valid ← 0, obs_count ← obs_count+1 (saturates at 255), next state LOAD.
  - Ticks during SPAWN are ignored; the gap does not run while stalled.
- Collision, priority over everything in LOAD/WAIT/SPAWN:
  - collision=1 → HALT on the next edge.
  - spawn_valid ← 0, even if spawn_ready is asserted the same cycle; that handshake does not count.
  - halted ← 1.
  - gap_count, obs_type, obs_height and obs_count freeze.
- HALT:
  - Ignores tick and spawn_ready.
  - game_active=0 → IDLE, halted ← 0, gap_count ← 0.
- game_active=0 in LOAD/WAIT/SPAWN without collision → IDLE.
  - spawn_valid ← 0, gap_count ← 0; obs_count is retained until the next game start.
- Simultaneous collision and game_active falling → HALT; it exits to IDLE on the following cycle.
- Reset asserted mid-operation: immediate return to reset values, regardless of state.
- random_in is sampled only in LOAD; changes at other times have no effect.

Test Plan:
- Reset, then game_active=1 with random_in=5'b10110, speed_level=0:
  - LOAD sets gap_count=14, obs_type=1, obs_height=0.
  - spawn_valid rises the cycle after the 14th tick.
- random_in=5'b11111, speed_level=2, spawn_ready=1:
  - gap = 8+(15>>2) = 11.
  - obs_type=2, obs_height=1.
  - spawn_valid is high for exactly 1 cycle; obs_count=1.
- Hold spawn_ready=0 for 20 cycles with 5 ticks while spawn_valid=1:
  - outputs stay stable, gap_count stays 0.
  - Assert ready → accepted once, back to LOAD.
- collision during WAIT at gap_count=5:
  - halted=1 next cycle; gap_count stays 5 through 10 further ticks.
  - Dropping game_active → IDLE, halted=0, gap_count=0.
- collision and spawn_ready in the same SPAWN cycle:
  - spawn_valid=0, obs_count unchanged, state HALT.
- Accept 260 spawns with MIN_GAP=1 and ticks every cycle:
  - obs_count saturates at 255.
  - Restarting the game clears it to 0.
  - Async rst_n low mid-WAIT → all outputs 0 immediately.
